stack_arbiter: RTL and testbench

- Shares one stack_behaviour_easy instance between N requesters.
- Grants one request at a time in round-robin order and drives the stack's COMMAND/INDEX/I_DATA.
- Returns the stack's read data with a response strobe and the winner's ID.
- Tracks stack occupancy and rejects illegal operations (overflow, underflow, out-of-range GET) before they reach the stack.

---
 rtl/stack_arbiter.sv | 140 ++++++++++++++
 tb/tb_stack_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - round-robin arbiter sharing one stack among N requesters
module stack_arbiter #(
  parameter int N     = 4,
  parameter int DEPTH = 5,
  parameter int DW    = 4,
  parameter int IW    = 3,
  localparam int NW   = $clog2(N),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [N-1:0]    REQ,
  input  logic [2*N-1:0]  CMD,
  input  logic [IW*N-1:0] IDX,
  input  logic [DW*N-1:0] WDATA,
  output logic [N-1:0]    GNT,
  output logic [1:0]      ST_COMMAND,
  output logic [IW-1:0]   ST_INDEX,
  output logic [DW-1:0]   ST_WDATA,
  input  logic [DW-1:0]   ST_RDATA,
  output logic            RVALID,
  output logic [DW-1:0]   RDATA,
  output logic [NW-1:0]   RID,
  output logic            ERR,
  output logic [CW-1:0]   COUNT
);

  localparam int MW = (IW > CW) ? IW : CW;

  localparam logic [1:0] C_NOP  = 2'b00;
  localparam logic [1:0] C_PUSH = 2'b01;
  localparam logic [1:0] C_POP  = 2'b10;
  localparam logic [1:0] C_GET  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic [NW-1:0] rr_ptr;
  logic [NW-1:0] win_id;
  logic [1:0]    cur_cmd;
  logic          cur_legal;
  logic          cur_rd;

  logic          any_req;
  logic [NW-1:0] win;
  logic [1:0]    w_cmd;
  logic [IW-1:0] w_idx;
  logic [DW-1:0] w_data;
  logic          w_legal;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % N;
      if (!any_req && REQ[j]) begin
        any_req = 1'b1;
        win     = NW'(j);
      end
    end
    w_cmd  = CMD[2*win +: 2];
    w_idx  = IDX[IW*win +: IW];
    w_data = WDATA[DW*win +: DW];
    case (w_cmd)
      C_PUSH:  w_legal = (COUNT < CW'(DEPTH));
      C_POP:   w_legal = (COUNT != '0);
      C_GET:   w_legal = (MW'(w_idx) < MW'(COUNT));
      default: w_legal = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      rr_ptr     <= NW'(N - 1);
      win_id     <= '0;
      cur_cmd    <= C_NOP;
      cur_legal  <= 1'b0;
      cur_rd     <= 1'b0;
      GNT        <= '0;
      ST_COMMAND <= C_NOP;
      ST_INDEX   <= '0;
      ST_WDATA   <= '0;
      RVALID     <= 1'b0;
      RDATA      <= '0;
      RID        <= '0;
      ERR        <= 1'b0;
      COUNT      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            GNT        <= {{(N-1){1'b0}}, 1'b1} << win;
            rr_ptr     <= win;
            win_id     <= win;
            cur_cmd    <= w_cmd;
            cur_legal  <= w_legal;
            cur_rd     <= w_legal && (w_cmd == C_POP || w_cmd == C_GET);
            ST_COMMAND <= w_legal ? w_cmd : C_NOP;
            ST_INDEX   <= w_idx;
            ST_WDATA   <= w_data;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          GNT        <= '0;
          ST_COMMAND <= C_NOP;
          if (cur_legal && cur_cmd == C_PUSH) COUNT <= COUNT + CW'(1);
          if (cur_legal && cur_cmd == C_POP)  COUNT <= COUNT - CW'(1);
          if (cur_rd) begin
            state <= WAIT;
          end else begin
            RVALID <= 1'b1;
            RDATA  <= '0;
            RID    <= win_id;
            ERR    <= ~cur_legal;
            state  <= DONE;
          end
        end
        WAIT: begin
          RVALID <= 1'b1;
          RDATA  <= ST_RDATA;
          RID    <= win_id;
          ERR    <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          RVALID <= 1'b0;
          RDATA  <= '0;
          ERR    <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - directed self-checking bench for stack_arbiter
module tb_stack_arbiter;

  logic        CLK;
  logic        RESET;
  logic [3:0]  REQ;
  logic [7:0]  CMD;
  logic [11:0] IDX;
  logic [15:0] WDATA;
  logic [3:0]  GNT;
  logic [1:0]  ST_COMMAND;
  logic [2:0]  ST_INDEX;
  logic [3:0]  ST_WDATA;
  logic [3:0]  ST_RDATA;
  logic        RVALID;
  logic [3:0]  RDATA;
  logic [1:0]  RID;
  logic        ERR;
  logic [2:0]  COUNT;

  int total = 0;
  int bad   = 0;

  stack_arbiter dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .CMD(CMD), .IDX(IDX), .WDATA(WDATA),
    .GNT(GNT), .ST_COMMAND(ST_COMMAND), .ST_INDEX(ST_INDEX), .ST_WDATA(ST_WDATA),
    .ST_RDATA(ST_RDATA), .RVALID(RVALID), .RDATA(RDATA), .RID(RID), .ERR(ERR),
    .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural stack: entry 0 is the bottom, read data registered.
  logic [3:0] smem [0:7];
  int         sp;
  logic [3:0] sdata;
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sp    <= 0;
      sdata <= '0;
    end else begin
      case (ST_COMMAND)
        2'b01: begin smem[sp] <= ST_WDATA; sp <= sp + 1; end
        2'b10: begin sdata <= smem[sp-1]; sp <= sp - 1; end
        2'b11: sdata <= smem[ST_INDEX];
        default: ;
      endcase
    end
  end
  assign ST_RDATA = sdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    REQ = '0; CMD = '0; IDX = '0; WDATA = '0;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic set_req(input int r, input logic [1:0] c, input logic [2:0] ix, input logic [3:0] wd);
    REQ[r]        = 1'b1;
    CMD[2*r +: 2] = c;
    IDX[3*r +: 3] = ix;
    WDATA[4*r +: 4] = wd;
  endtask

  task automatic run_txn(input string tag, input int exp_win, input logic [1:0] exp_fwd,
                         input logic exp_err, input logic [3:0] exp_rdata,
                         input int exp_lat, input int exp_count);
    int lat;
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge CLK); #1;
      if (GNT != '0) seen = 1;
    end
    if (!seen) begin
      check({tag, "_gnt_timeout"}, 0, 1);
      return;
    end
    check({tag, "_gnt"}, GNT, 32'(4'b0001 << exp_win));
    check({tag, "_stcmd"}, ST_COMMAND, exp_fwd);
    check({tag, "_stwdata"}, ST_WDATA, WDATA[4*exp_win +: 4]);
    check({tag, "_stindex"}, ST_INDEX, IDX[3*exp_win +: 3]);
    REQ[exp_win] = 1'b0;
    lat  = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge CLK); #1;
      lat++;
      if (RVALID) seen = 1;
    end
    if (!seen) begin
      check({tag, "_rvalid_timeout"}, 0, 1);
      return;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rid"}, RID, exp_win);
    check({tag, "_err"}, ERR, exp_err);
    check({tag, "_rdata"}, RDATA, exp_rdata);
    check({tag, "_count"}, COUNT, exp_count);
    check({tag, "_gnt_low"}, GNT, 0);
    check({tag, "_stcmd_nop"}, ST_COMMAND, 0);
  endtask

  initial begin
    do_reset();
    check("rst_gnt", GNT, 0);
    check("rst_stcmd", ST_COMMAND, 0);
    check("rst_stidx", ST_INDEX, 0);
    check("rst_stwd", ST_WDATA, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rdata", RDATA, 0);
    check("rst_rid", RID, 0);
    check("rst_err", ERR, 0);
    check("rst_count", COUNT, 0);

    // single push
    set_req(0, 2'b01, 3'd0, 4'h3);
    run_txn("t1_push", 0, 2'b01, 1'b0, 4'h0, 2, 1);

    // four simultaneous pushes, then a second round starting at 0
    do_reset();
    set_req(0, 2'b01, 3'd0, 4'h1);
    set_req(1, 2'b01, 3'd0, 4'h2);
    set_req(2, 2'b01, 3'd0, 4'h3);
    set_req(3, 2'b01, 3'd0, 4'h4);
    run_txn("t2_p0", 0, 2'b01, 1'b0, 4'h0, 2, 1);
    run_txn("t2_p1", 1, 2'b01, 1'b0, 4'h0, 2, 2);
    run_txn("t2_p2", 2, 2'b01, 1'b0, 4'h0, 2, 3);
    run_txn("t2_p3", 3, 2'b01, 1'b0, 4'h0, 2, 4);
    set_req(0, 2'b00, 3'd0, 4'h0);
    set_req(2, 2'b00, 3'd0, 4'h0);
    run_txn("t2_nop0", 0, 2'b00, 1'b0, 4'h0, 2, 4);
    run_txn("t2_nop2", 2, 2'b00, 1'b0, 4'h0, 2, 4);

    // fill to 5, then overflow
    set_req(3, 2'b01, 3'd0, 4'h5);
    run_txn("t3_fill", 3, 2'b01, 1'b0, 4'h0, 2, 5);
    set_req(2, 2'b01, 3'd0, 4'h6);
    run_txn("t3_ovf", 2, 2'b00, 1'b1, 4'h0, 2, 5);

    // GET in range and out of range
    set_req(1, 2'b11, 3'd2, 4'h0);
    run_txn("t4_get2", 1, 2'b11, 1'b0, 4'h3, 3, 5);
    set_req(1, 2'b11, 3'd5, 4'h0);
    run_txn("t4_get5", 1, 2'b00, 1'b1, 4'h0, 2, 5);

    // three pushes, five pops
    do_reset();
    set_req(0, 2'b01, 3'd0, 4'h7);
    run_txn("t5_push7", 0, 2'b01, 1'b0, 4'h0, 2, 1);
    set_req(0, 2'b01, 3'd0, 4'h8);
    run_txn("t5_push8", 0, 2'b01, 1'b0, 4'h0, 2, 2);
    set_req(0, 2'b01, 3'd0, 4'h9);
    run_txn("t5_push9", 0, 2'b01, 1'b0, 4'h0, 2, 3);
    set_req(0, 2'b10, 3'd0, 4'h0);
    run_txn("t5_pop1", 0, 2'b10, 1'b0, 4'h9, 3, 2);
    set_req(0, 2'b10, 3'd0, 4'h0);
    run_txn("t5_pop2", 0, 2'b10, 1'b0, 4'h8, 3, 1);
    set_req(0, 2'b10, 3'd0, 4'h0);
    run_txn("t5_pop3", 0, 2'b10, 1'b0, 4'h7, 3, 0);
    set_req(0, 2'b10, 3'd0, 4'h0);
    run_txn("t5_pop4", 0, 2'b00, 1'b1, 4'h0, 2, 0);
    set_req(0, 2'b10, 3'd0, 4'h0);
    run_txn("t5_pop5", 0, 2'b00, 1'b1, 4'h0, 2, 0);

    // reset during WAIT of a POP
    do_reset();
    set_req(0, 2'b01, 3'd0, 4'hA);
    run_txn("t6_push", 0, 2'b01, 1'b0, 4'h0, 2, 1);
    set_req(0, 2'b10, 3'd0, 4'h0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge CLK); #1;
        if (GNT != '0) seen = 1;
      end
      check("t6_pop_gnt", GNT, 4'b0001);
      check("t6_pop_stcmd", ST_COMMAND, 2'b10);
      REQ[0] = 1'b0;
    end
    @(posedge CLK); #1;
    check("t6_wait_rvalid", RVALID, 0);
    RESET = 1'b1;
    #1;
    check("t6_rst_gnt", GNT, 0);
    check("t6_rst_stcmd", ST_COMMAND, 0);
    check("t6_rst_stidx", ST_INDEX, 0);
    check("t6_rst_stwd", ST_WDATA, 0);
    check("t6_rst_rvalid", RVALID, 0);
    check("t6_rst_rdata", RDATA, 0);
    check("t6_rst_rid", RID, 0);
    check("t6_rst_err", ERR, 0);
    check("t6_rst_count", COUNT, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      check("t6_no_rvalid", RVALID, 0);
    end
    set_req(0, 2'b00, 3'd0, 4'h0);
    set_req(3, 2'b00, 3'd0, 4'h0);
    run_txn("t6_next0", 0, 2'b00, 1'b0, 4'h0, 2, 0);
    run_txn("t6_next3", 3, 2'b00, 1'b0, 4'h0, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
